// File: rtl/datapath_if.sv
`default_nettype none
// ============================================================================
// datapath_if : control word, operand and result bundle for datapath
// Rev 1.0
// ============================================================================
interface datapath_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              enable;
  logic [1:0]        SelA;
  logic              SelB;
  logic              WrAcc;
  logic              Op;
  logic              WrRam;
  logic              RdRam;
  logic [ADDR_W-1:0] Operand;
  logic [DATA_W-1:0] Acc;
  logic [DATA_W-1:0] MemData;
  logic              Zero;
  logic              Neg;
  logic              Ovf;

  modport master (
    output enable, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
    input  Acc, MemData, Zero, Neg, Ovf
  );

  modport slave (
    input  enable, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand,
    output Acc, MemData, Zero, Neg, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// datapath : BIP accumulator, add/sub ALU, sign-extender and data memory.
// Optional status flags enabled by macro DATAPATH_FLAGS_EN.
// Rev 1.0
// ============================================================================
module datapath #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 11,
  parameter string DATA_FILE = ""
) (
  input wire logic  clk,
  input wire logic  reset,
  datapath_if.slave bus
);
  localparam int         c_DEPTH   = 1 << ADDR_W;
  localparam logic [1:0] c_SEL_MEM = 2'b00;
  localparam logic [1:0] c_SEL_IMM = 2'b01;
  localparam logic [1:0] c_SEL_ALU = 2'b10;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [DATA_W-1:0] r_acc;

  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_acc_nxt;
  logic              w_commit;
  logic              w_acc_we;
  logic              w_ram_we;

  assign w_imm      = DATA_W'($signed(bus.Operand));
  assign w_mem_data = bus.RdRam ? r_mem[bus.Operand] : '0;
  assign w_alu_b    = bus.SelB ? w_imm : w_mem_data;
  assign w_alu_res  = bus.Op ? (r_acc - w_alu_b) : (r_acc + w_alu_b);

  assign w_commit = reset & bus.enable;
  assign w_acc_we = w_commit & bus.WrAcc;
  assign w_ram_we = w_commit & bus.WrRam;

  // SelA=11 is reserved and simply recirculates the accumulator
  always_comb begin
    w_acc_nxt = r_acc;
    case (bus.SelA)
      c_SEL_MEM: w_acc_nxt = w_mem_data;
      c_SEL_IMM: w_acc_nxt = w_imm;
      c_SEL_ALU: w_acc_nxt = w_alu_res;
      default:   w_acc_nxt = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (w_acc_we) begin
      r_acc <= w_acc_nxt;
    end
  end

  // Memory captures the pre-edge accumulator and is never cleared by reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[bus.Operand] <= r_acc;
    end
  end

  assign bus.Acc     = r_acc;
  assign bus.MemData = w_mem_data;

`ifdef DATAPATH_FLAGS_EN
  logic w_ovf;
  logic r_zero;
  logic r_neg;
  logic r_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (bus.Op) begin
      w_ovf = (r_acc[DATA_W-1] != w_alu_b[DATA_W-1]) &&
              (w_alu_res[DATA_W-1] != r_acc[DATA_W-1]);
    end else begin
      w_ovf = (r_acc[DATA_W-1] == w_alu_b[DATA_W-1]) &&
              (w_alu_res[DATA_W-1] != r_acc[DATA_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_acc_we) begin
      r_zero <= (w_acc_nxt == '0);
      r_neg  <= w_acc_nxt[DATA_W-1];
      r_ovf  <= (bus.SelA == c_SEL_ALU) && w_ovf;
    end
  end

  assign bus.Zero = r_zero;
  assign bus.Neg  = r_neg;
  assign bus.Ovf  = r_ovf;
`else
  assign bus.Zero = 1'b0;
  assign bus.Neg  = 1'b0;
  assign bus.Ovf  = 1'b0;
`endif

endmodule
`default_nettype wire
